// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline: load-use stall, branch flush and
// data-memory wait with timeout; all outputs come straight from flops.
module pipe_hazard_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  d_dest,
  input  logic        d_memread,
  input  logic [3:0]  f_op1,
  input  logic [3:0]  f_op2,
  input  logic        br_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dx_en,
  output logic        xm_en,
  output logic        mw_en,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDUSE   = 2'b01,
    FLUSH   = 2'b10,
    MEMWAIT = 2'b11
  } state_e;

  state_e      state_r;
  state_e      next_s;
  logic [6:0]  ctl_r;
  logic [15:0] stall_cnt_r;
  logic        mem_err_r;
  logic        br_pend_r;
  logic        br_pend_next_s;
  logic [7:0]  wait_cnt_r;
  logic [7:0]  wait_next_s;
  logic        err_set_s;
  logic        ld_hz_s;

  // Control vector order: {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush}
  function automatic logic [6:0] decode_ctl(input state_e st);
    case (st)
      RUN:     decode_ctl = 7'b11111_00;
      LDUSE:   decode_ctl = 7'b00111_01;
      FLUSH:   decode_ctl = 7'b11111_11;
      MEMWAIT: decode_ctl = 7'b00000_00;
      default: decode_ctl = 7'b11111_00;
    endcase
  endfunction

  function automatic state_e run_next(input logic req, input logic ack,
                                      input logic br, input logic ld);
    if (req && !ack) begin
      run_next = MEMWAIT;
    end else if (br) begin
      run_next = FLUSH;
    end else if (ld) begin
      run_next = LDUSE;
    end else begin
      run_next = RUN;
    end
  endfunction

  assign ld_hz_s = d_memread && (d_dest != 4'd0) &&
                   ((d_dest == f_op1) || (d_dest == f_op2));

  // Next-state, wait counter and pending-branch logic
  always_comb begin
    next_s         = RUN;
    br_pend_next_s = 1'b0;
    wait_next_s    = 8'd0;
    err_set_s      = 1'b0;
    case (state_r)
      RUN:   next_s = run_next(mem_req, mem_ack, br_taken, ld_hz_s);
      LDUSE: next_s = run_next(mem_req, mem_ack, br_taken, ld_hz_s);
      FLUSH: next_s = run_next(mem_req, mem_ack, br_taken, 1'b0);
      MEMWAIT: begin
        if (mem_ack) begin
          next_s = (br_pend_r || br_taken) ? FLUSH : RUN;
        end else if (wait_cnt_r == TIMEOUT) begin
          // Abandon the access; any branch seen while waiting is dropped
          next_s    = RUN;
          err_set_s = 1'b1;
        end else begin
          next_s         = MEMWAIT;
          wait_next_s    = wait_cnt_r + 8'd1;
          br_pend_next_s = br_pend_r || br_taken;
        end
      end
      default: next_s = RUN;
    endcase
  end

  // State, registered controls and bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      ctl_r       <= 7'b11111_00;
      stall_cnt_r <= 16'd0;
      mem_err_r   <= 1'b0;
      br_pend_r   <= 1'b0;
      wait_cnt_r  <= 8'd0;
    end else begin
      state_r    <= next_s;
      ctl_r      <= decode_ctl(next_s);
      br_pend_r  <= br_pend_next_s;
      wait_cnt_r <= wait_next_s;
      if (err_set_s) begin
        mem_err_r <= 1'b1;
      end else begin
        mem_err_r <= mem_err_r;
      end
      if ((state_r != RUN) && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign pc_en     = ctl_r[6];
  assign fd_en     = ctl_r[5];
  assign dx_en     = ctl_r[4];
  assign xm_en     = ctl_r[3];
  assign mw_en     = ctl_r[2];
  assign fd_flush  = ctl_r[1];
  assign dx_flush  = ctl_r[0];
  assign state     = state_r;
  assign stall_cnt = stall_cnt_r;
  assign mem_err   = mem_err_r;

endmodule
